// File: rtl/pack_param_pkg.sv
// Shared definitions for the parametrised pack stage: value classes,
// exponent constants and the special-value encodings.
package pack_pkg;

    // Class of the value travelling down the pack pipeline
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_FINITE,
        CLS_PINF,
        CLS_NINF,
        CLS_NAN
    } pack_cls_e;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_ones_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Quiet NaN: sign set, all-ones exponent, fraction MSB set
    function automatic logic [63:0] nan_word(input int exp_w, input int mant_w);
        return (64'd1 << (exp_w + mant_w))
             | (64'(exp_ones_of(exp_w)) << mant_w)
             | (64'd1 << (mant_w - 1));
    endfunction

    // Signed infinity: all-ones exponent, zero fraction
    function automatic logic [63:0] inf_word(input logic sign, input int exp_w, input int mant_w);
        return (64'(sign) << (exp_w + mant_w))
             | (64'(exp_ones_of(exp_w)) << mant_w);
    endfunction

endpackage

// File: rtl/pack_param_if.sv
// Beat interface of the pack stage: upstream triple/flags with valid/ready,
// downstream packed word, class and exception flags with valid/ready.
interface pack_param_if #(
    parameter int EXP_W   = 5,
    parameter int MANT_W  = 10,
    parameter int GUARD_W = 3,
    parameter int TAG_W   = 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          sign_in;
    logic signed [EXP_W+1:0]       exp_in;
    logic [MANT_W+GUARD_W:0]       mant_in;
    logic                          is_nan_in;
    logic                          is_pinf_in;
    logic                          is_ninf_in;
    logic [TAG_W-1:0]              tag_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [EXP_W+MANT_W:0]         out_data;
    logic [TAG_W-1:0]              tag_out;
    logic                          is_nan_out;
    logic                          is_pinf_out;
    logic                          is_ninf_out;
    logic                          flag_overflow;
    logic                          flag_underflow;
    logic                          flag_inexact;

    modport master (
        output in_valid, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in,
               is_ninf_in, tag_in, out_ready,
        input  in_ready, out_valid, out_data, tag_out, is_nan_out,
               is_pinf_out, is_ninf_out, flag_overflow, flag_underflow,
               flag_inexact
    );

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in,
               is_ninf_in, tag_in, out_ready,
        output in_ready, out_valid, out_data, tag_out, is_nan_out,
               is_pinf_out, is_ninf_out, flag_overflow, flag_underflow,
               flag_inexact
    );
endinterface

// File: rtl/pack_param_round.sv
// Round-to-nearest-even of a stored fraction given its guard and sticky bits.
// A carry out means the fraction wrapped to zero and the exponent must step.
module pack_round #(
    parameter int MANT_W = 10
) (
    input  logic [MANT_W-1:0] frac,
    input  logic              guard,
    input  logic              sticky,
    output logic [MANT_W-1:0] frac_out,
    output logic              carry,
    output logic              inexact
);
    logic inc;

    assign inc                = guard && (sticky || frac[0]);
    assign {carry, frac_out}  = {1'b0, frac} + {{MANT_W{1'b0}}, inc};
    assign inexact            = guard || sticky;
endmodule

// File: rtl/pack_param.sv
// Parametrised pack stage: unbiased sign/exponent/mantissa plus special flags
// into a packed {sign, exp, frac} word with RNE rounding, overflow to infinity
// and exception flags. Two-stage valid/ready pipeline with backpressure.
// Build option: define PACK_FTZ_EN to flush tiny results to signed zero
// instead of producing subnormals.
module pack_param
    import pack_pkg::*;
#(
    parameter int EXP_W   = 5,
    parameter int MANT_W  = 10,
    parameter int GUARD_W = 3,
    parameter int TAG_W   = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enable,
    pack_param_if.slave bus
);
    localparam int MW = MANT_W + 1 + GUARD_W;
    localparam int W  = 1 + EXP_W + MANT_W;

    localparam logic signed [EXP_W+1:0] BIAS_S     = (EXP_W+2)'(bias_of(EXP_W));
    localparam logic signed [EXP_W+1:0] EXP_ONES_S = (EXP_W+2)'(exp_ones_of(EXP_W));
    localparam logic [EXP_W:0]          EXP_ONES_U = (EXP_W+1)'(exp_ones_of(EXP_W));
    localparam logic [63:0]             NAN_W64    = nan_word(EXP_W, MANT_W);
    localparam logic [63:0]             PINF_W64   = inf_word(1'b0, EXP_W, MANT_W);
    localparam logic [63:0]             NINF_W64   = inf_word(1'b1, EXP_W, MANT_W);
    localparam logic [W-1:0]            NAN_ENC    = NAN_W64[W-1:0];
    localparam logic [W-1:0]            PINF_ENC   = PINF_W64[W-1:0];
    localparam logic [W-1:0]            NINF_ENC   = NINF_W64[W-1:0];

    logic s2_free, s1_ready;

    logic              vld_p1;
    pack_cls_e         cls_p1;
    logic              sign_p1, sticky_p1, tiny_p1, ovf_p1, inx_p1;
    logic [EXP_W-1:0]  expf_p1;
    logic [MW-2:0]     mant_p1;
    logic [TAG_W-1:0]  tag_p1;

    pack_cls_e         cls_d;
    logic              sticky_d, tiny_d, ovf_d, inx_d, eb_tiny;
    logic [EXP_W-1:0]  expf_d;
    logic [MW-2:0]     mant_d;
    logic signed [EXP_W+1:0] eb;

    assign s2_free      = !bus.out_valid || bus.out_ready;
    assign s1_ready     = !vld_p1 || s2_free;
    assign bus.in_ready = enable && rst_n && s1_ready;

    assign eb      = bus.exp_in + BIAS_S;
    assign eb_tiny = eb[EXP_W+1] || (eb == '0);

`ifndef PACK_FTZ_EN
    logic [EXP_W+2:0] sh;
    logic [MW-2:0]    shifted;
    logic [MW-1:0]    lost;

    assign sh      = (EXP_W+3)'(1) - {eb[EXP_W+1], eb};
    assign shifted = (MW-1)'(bus.mant_in >> sh);
    assign lost    = bus.mant_in & ~({MW{1'b1}} << sh);
`endif

    // ---- S1: classify, bias the exponent, align tiny values, gather sticky
    // Decide the class and the aligned mantissa for the incoming beat
    always_comb begin
        cls_d    = CLS_FINITE;
        expf_d   = eb[EXP_W-1:0];
        mant_d   = bus.mant_in[MW-2:0];
        sticky_d = 1'b0;
        tiny_d   = 1'b0;
        ovf_d    = 1'b0;
        inx_d    = 1'b0;
        if (bus.is_nan_in) begin
            cls_d = CLS_NAN;
        end else if (bus.is_pinf_in) begin
            cls_d = CLS_PINF;
        end else if (bus.is_ninf_in) begin
            cls_d = CLS_NINF;
        end else if (bus.mant_in == '0) begin
            cls_d = CLS_ZERO;
        end else if (eb >= EXP_ONES_S) begin
            cls_d = bus.sign_in ? CLS_NINF : CLS_PINF;
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (eb_tiny) begin
            tiny_d = 1'b1;
            expf_d = '0;
`ifdef PACK_FTZ_EN
            cls_d  = CLS_ZERO;
            inx_d  = 1'b1;
`else
            mant_d   = shifted;
            sticky_d = |lost;
`endif
        end
    end

    // S1 valid: cleared by reset or disable, advances when S1 can take a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (!enable) begin
            vld_p1 <= 1'b0;
        end else if (s1_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    // S1 data captured on every accepted beat
    always_ff @(posedge clk) begin
        if (enable && s1_ready && bus.in_valid) begin
            cls_p1    <= cls_d;
            sign_p1   <= bus.sign_in;
            expf_p1   <= expf_d;
            mant_p1   <= mant_d;
            sticky_p1 <= sticky_d;
            tiny_p1   <= tiny_d;
            ovf_p1    <= ovf_d;
            inx_p1    <= inx_d;
            tag_p1    <= bus.tag_in;
        end
    end

    // ---- S2: round, assemble, output register
    logic [MANT_W-1:0] frac_rnd;
    logic              rnd_carry, rnd_inx;
    logic [EXP_W:0]    exp_sum;
    logic [W-1:0]      data_d;
    logic              nan_d, pinf_d, ninf_d, ovf_o, uf_o, inx_o;

    pack_round #(.MANT_W(MANT_W)) u_round (
        .frac     (mant_p1[MW-2:GUARD_W]),
        .guard    (mant_p1[GUARD_W-1]),
        .sticky   (sticky_p1 | (|mant_p1[GUARD_W-2:0])),
        .frac_out (frac_rnd),
        .carry    (rnd_carry),
        .inexact  (rnd_inx)
    );

    assign exp_sum = {1'b0, expf_p1} + {{EXP_W{1'b0}}, rnd_carry};

    // Build the packed word and the flags for the beat held in S1
    always_comb begin
        data_d = '0;
        nan_d  = 1'b0;
        pinf_d = 1'b0;
        ninf_d = 1'b0;
        ovf_o  = 1'b0;
        uf_o   = 1'b0;
        inx_o  = 1'b0;
        case (cls_p1)
            CLS_NAN: begin
                data_d = NAN_ENC;
                nan_d  = 1'b1;
            end
            CLS_PINF: begin
                data_d = PINF_ENC;
                pinf_d = 1'b1;
                ovf_o  = ovf_p1;
                inx_o  = inx_p1;
            end
            CLS_NINF: begin
                data_d = NINF_ENC;
                ninf_d = 1'b1;
                ovf_o  = ovf_p1;
                inx_o  = inx_p1;
            end
            CLS_ZERO: begin
                data_d = {sign_p1, {(W-1){1'b0}}};
                inx_o  = inx_p1;
                uf_o   = tiny_p1 && inx_p1;
            end
            default: begin
                inx_o = rnd_inx;
                uf_o  = tiny_p1 && rnd_inx;
                if (exp_sum >= EXP_ONES_U) begin
                    data_d = sign_p1 ? NINF_ENC : PINF_ENC;
                    pinf_d = !sign_p1;
                    ninf_d = sign_p1;
                    ovf_o  = 1'b1;
                    inx_o  = 1'b1;
                end else begin
                    data_d = {sign_p1, exp_sum[EXP_W-1:0], frac_rnd};
                end
            end
        endcase
    end

    // Output register: cleared by reset or disable, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !enable) begin
            bus.out_valid      <= 1'b0;
            bus.out_data       <= '0;
            bus.tag_out        <= '0;
            bus.is_nan_out     <= 1'b0;
            bus.is_pinf_out    <= 1'b0;
            bus.is_ninf_out    <= 1'b0;
            bus.flag_overflow  <= 1'b0;
            bus.flag_underflow <= 1'b0;
            bus.flag_inexact   <= 1'b0;
        end else if (s2_free) begin
            bus.out_valid <= vld_p1;
            if (vld_p1) begin
                bus.out_data       <= data_d;
                bus.tag_out        <= tag_p1;
                bus.is_nan_out     <= nan_d;
                bus.is_pinf_out    <= pinf_d;
                bus.is_ninf_out    <= ninf_d;
                bus.flag_overflow  <= ovf_o;
                bus.flag_underflow <= uf_o;
                bus.flag_inexact   <= inx_o;
            end
        end
    end
endmodule

// File: tb/tb_pack_param.sv
// Bench for pack_param at the fp16 defaults: directed corner beats, a random
// stream against an arithmetic reference model, backpressure, flush and reset.
module tb_pack_param;
    localparam int EXP_W   = 5;
    localparam int MANT_W  = 10;
    localparam int GUARD_W = 3;
    localparam int TAG_W   = 1;
    localparam int MW      = MANT_W + 1 + GUARD_W;
    localparam int W       = 1 + EXP_W + MANT_W;
    localparam int VW      = W + TAG_W + 6;

    localparam longint BIAS     = (1 << (EXP_W - 1)) - 1;
    localparam longint EMAX     = (1 << EXP_W) - 1;
    localparam longint INF_MAG  = EMAX << MANT_W;
    localparam longint SIGN_BIT = longint'(1) << (W - 1);
    localparam longint NAN_WORD = SIGN_BIT | INF_MAG | (longint'(1) << (MANT_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    pack_param_if #(.EXP_W(EXP_W), .MANT_W(MANT_W), .GUARD_W(GUARD_W), .TAG_W(TAG_W)) bus ();

    pack_param #(.EXP_W(EXP_W), .MANT_W(MANT_W), .GUARD_W(GUARD_W), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_acc   = 0;
    int               n_pop   = 0;
    logic [VW-1:0]    sb_q[$];
    logic             held_v  = 1'b0;
    logic [VW-1:0]    held_vec;

    // Reference: value = mant * 2^(exp-MANT_W-GUARD_W); quantise to the ulp of
    // the target binade (or the subnormal ulp) with ties to even.
    function automatic logic [VW-1:0] model(input logic s, input int e, input logic [MW-1:0] m,
                                            input logic nan, input logic pinf, input logic ninf,
                                            input logic [TAG_W-1:0] tg);
        longint dl, eb, shv, n, r, half, mag;
        logic fn, fp, fq, ov, uf, ix;
        dl = 0; fn = 0; fp = 0; fq = 0; ov = 0; uf = 0; ix = 0;
        if (nan) begin
            dl = NAN_WORD; fn = 1'b1;
        end else if (pinf) begin
            dl = INF_MAG; fp = 1'b1;
        end else if (ninf) begin
            dl = SIGN_BIT | INF_MAG; fq = 1'b1;
        end else if (m == 0) begin
            dl = s ? SIGN_BIT : 0;
        end else begin
            eb = longint'(e) + BIAS;
            if (eb >= EMAX) begin
                mag = INF_MAG; ov = 1'b1; ix = 1'b1;
            end else begin
                shv = GUARD_W + ((eb <= 0) ? (1 - eb) : 0);
                if (shv > 40) shv = 40;
                n    = longint'(m) >> shv;
                r    = longint'(m) - (n << shv);
                half = longint'(1) << (shv - 1);
                if (r > half || (r == half && n[0])) n = n + 1;
                ix  = (r != 0);
                mag = (((eb > 1) ? eb : 1) - 1) * (longint'(1) << MANT_W) + n;
                if (mag >= INF_MAG) begin
                    mag = INF_MAG; ov = 1'b1;
                end
                uf = (eb <= 0) && ix;
`ifdef PACK_FTZ_EN
                if (eb <= 0) begin
                    mag = 0; uf = 1'b1; ix = 1'b1;
                end
`endif
            end
            dl = (s ? SIGN_BIT : 0) | mag;
            fp = ov && !s;
            fq = ov && s;
        end
        return {W'(dl), tg, fn, fp, fq, ov, uf, ix};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.out_data, bus.tag_out, bus.is_nan_out, bus.is_pinf_out, bus.is_ninf_out,
                bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    task automatic set_beat(input logic s, input int e, input logic [MW-1:0] m, input logic nan,
                            input logic pinf, input logic ninf, input logic [TAG_W-1:0] tg);
        bus.in_valid   = 1'b1;
        bus.sign_in    = s;
        bus.exp_in     = (EXP_W+2)'(e);
        bus.mant_in    = m;
        bus.is_nan_in  = nan;
        bus.is_pinf_in = pinf;
        bus.is_ninf_in = ninf;
        bus.tag_in     = tg;
    endtask

    task automatic rand_beat();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 4)       set_beat(1'($urandom), 0, 14'h2000, 1'b1, 1'($urandom), 1'b0, TAG_W'($urandom));
        else if (sel < 8)  set_beat(1'($urandom), 0, 14'h2000, 1'b0, 1'b1, 1'b0, TAG_W'($urandom));
        else if (sel < 12) set_beat(1'($urandom), 0, 14'h2000, 1'b0, 1'b0, 1'b1, TAG_W'($urandom));
        else if (sel < 17) set_beat(1'($urandom), $urandom_range(0, 40) - 20, '0, 1'b0, 1'b0, 1'b0, TAG_W'($urandom));
        else set_beat(1'($urandom), $urandom_range(0, 48) - 30, {1'b1, 13'($urandom)},
                      1'b0, 1'b0, 1'b0, TAG_W'($urandom));
    endtask

    // Called at a negedge after the inputs are set: record what the next edge
    // transfers, check holds while stalled, then move to the next negedge.
    task automatic step();
        #1;
        if (held_v) chk("hold", 64'({bus.out_valid, obs_vec()}), 64'({1'b1, held_vec}));
        if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.sign_in, int'(bus.exp_in), bus.mant_in, bus.is_nan_in,
                                 bus.is_pinf_in, bus.is_ninf_in, bus.tag_in));
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_beat observed=0x%0h expected=none", obs_vec());
            end
            if (sb_q.size() > 0) begin
                chk("stream", 64'(obs_vec()), 64'(sb_q.pop_front()));
                n_pop++;
            end
        end
        held_v   = bus.out_valid && !bus.out_ready;
        held_vec = obs_vec();
        @(negedge clk);
    endtask

    task automatic run_beat(input string name, input logic s, input int e, input logic [MW-1:0] m,
                            input logic nan, input logic pinf, input logic ninf,
                            input logic [TAG_W-1:0] tg, output logic [W-1:0] got);
        logic [VW-1:0] expv;
        bus.out_ready = 1'b1;
        set_beat(s, e, m, nan, pinf, ninf, tg);
        expv = model(s, e, m, nan, pinf, ninf, tg);
        for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
        chk({name, "_rdy"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk({name, "_lat2"}, 64'(bus.out_valid), 64'(1));
        chk(name, 64'(obs_vec()), 64'(expv));
        got = bus.out_data;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        int b;
        bus.in_valid = 1'b0; bus.sign_in = 1'b0; bus.exp_in = '0; bus.mant_in = '0;
        bus.is_nan_in = 1'b0; bus.is_pinf_in = 1'b0; bus.is_ninf_in = 1'b0;
        bus.tag_in = '0; bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_outputs", 64'(obs_vec()), 64'(0));
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);

        // Directed corner beats
        run_beat("one", 0, 0, 14'h2000, 0, 0, 0, 1'b1, got);
        chk("one_word", 64'(got), 64'h3C00);
        run_beat("ovf_round", 0, 15, 14'h3FFF, 0, 0, 0, 1'b0, got);
        chk("ovf_round_word", 64'(got), 64'h7C00);
        run_beat("max_normal", 0, 15, 14'h2000, 0, 0, 0, 1'b0, got);
        run_beat("ovf_exp", 1, 16, 14'h2000, 0, 0, 0, 1'b1, got);
        run_beat("sub_half", 0, -15, 14'h2000, 0, 0, 0, 1'b0, got);
`ifdef PACK_FTZ_EN
        chk("sub_half_word", 64'(got), 64'h0000);
`else
        chk("sub_half_word", 64'(got), 64'h0200);
`endif
        run_beat("sub_min", 0, -24, 14'h2000, 0, 0, 0, 1'b0, got);
`ifndef PACK_FTZ_EN
        chk("sub_min_word", 64'(got), 64'h0001);
`endif
        run_beat("sub_tie", 0, -25, 14'h2000, 0, 0, 0, 1'b0, got);
        chk("sub_tie_word", 64'(got), 64'h0000);
        run_beat("sub_carry", 0, -15, 14'h3FFF, 0, 0, 0, 1'b0, got);
        run_beat("rne_tie_odd", 0, 0, 14'h200C, 0, 0, 0, 1'b0, got);
        run_beat("rne_tie_even", 1, 3, 14'h2004, 0, 0, 0, 1'b0, got);
        run_beat("nan", 0, 0, 14'h2000, 1, 1, 0, 1'b0, got);
        chk("nan_word", 64'(got), 64'hFE00);
        run_beat("ninf", 0, 0, 14'h2000, 0, 0, 1, 1'b0, got);
        chk("ninf_word", 64'(got), 64'hFC00);
        run_beat("neg_zero", 1, 5, 14'h0000, 0, 0, 0, 1'b1, got);
        chk("neg_zero_word", 64'(got), 64'h8000);

        // Random stream with random backpressure
        sb_q.delete(); held_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rand_beat();
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
        chk("rand_drained", 64'(sb_q.size()), 64'(0));

        // Backpressure: four back-to-back beats, output stalled three cycles
        sb_q.delete(); held_v = 1'b0; n_acc = 0; n_pop = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            b = n_acc;
            set_beat(0, b - 2, 14'h2000 | MW'(b * 9), 0, 0, 0, TAG_W'(b));
            step();
        end
        chk("bp_accepted", 64'(n_acc), 64'(2));
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && n_pop < 4; c++) begin
            b = n_acc;
            if (b < 4) set_beat(0, b - 2, 14'h2000 | MW'(b * 9), 0, 0, 0, TAG_W'(b));
            else bus.in_valid = 1'b0;
            step();
        end
        chk("bp_emitted", 64'(n_pop), 64'(4));
        bus.in_valid = 1'b0;
        step();

        // Disable with two beats in flight drops them
        held_v = 1'b0;
        set_beat(0, 1, 14'h2100, 0, 0, 0, 1'b1);
        @(negedge clk);
        set_beat(1, 2, 14'h2200, 0, 0, 0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("flush_pre_valid", 64'(bus.out_valid), 64'(1));
        enable = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_outputs", 64'(obs_vec()), 64'(0));
        chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_no_ghost", 64'(bus.out_valid), 64'(0));
        end

        // Asynchronous reset pulse mid-stream
        set_beat(0, 4, 14'h2300, 0, 0, 0, 1'b0);
        @(negedge clk);
        set_beat(0, 5, 14'h2400, 0, 0, 0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("arst_outputs", 64'(obs_vec()), 64'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_beat("after_reset", 1, -3, 14'h2ABC, 0, 0, 0, 1'b1, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
